// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM states, destination
// field width and the default broadcast ID.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } arb_state_e;

    localparam int DEST_W = 8;
    localparam logic [DEST_W-1:0] BCAST_DEFAULT = 8'hFF;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: searches req starting just after 'last'
// and reports the first requester found.
module rr_priority_picker #(
    parameter int drvrs = 4,
    parameter int id_w  = (drvrs > 1) ? $clog2(drvrs) : 1
) (
    input  logic [drvrs-1:0] req,
    input  logic [id_w-1:0]  last,
    output logic             gnt_valid,
    output logic [id_w-1:0]  gnt_id
);

    int idx;

    // Walk from the farthest offset to the nearest so the closest requester
    // after 'last' is the final assignment and therefore wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int i = drvrs; i >= 1; i--) begin
            idx = (int'(last) + i) % drvrs;
            if (req[idx[id_w-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_id    = idx[id_w-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Shared-bus arbiter: round-robin grants among eligible devices, pops one word
// from the winner's FIFO and routes it to unicast, broadcast or drop.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int                drvrs     = 4,
    parameter int                pckg_sz   = 16,
    parameter logic [DEST_W-1:0] broadcast = BCAST_DEFAULT,
    parameter int                id_w      = (drvrs > 1) ? $clog2(drvrs) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         pndng,
    input  logic [drvrs*pckg_sz-1:0] D_pop,
    input  logic [drvrs-1:0]         en_mask,
    output logic [drvrs-1:0]         pop,
    output logic [drvrs-1:0]         push,
    output logic [pckg_sz-1:0]       D_push,
    output logic [id_w-1:0]          grant_id,
    output logic                     busy,
    output logic [7:0]               drop_cnt
);

    arb_state_e          state;
    logic [id_w-1:0]     last_grant;
    logic [pckg_sz-1:0]  packet;
    logic [drvrs-1:0]    eligible;
    logic                gnt_valid;
    logic [id_w-1:0]     gnt_id;
    logic [pckg_sz-1:0]  head;
    logic [DEST_W-1:0]   dest;
    logic [drvrs-1:0]    route_vec;
    logic                route_drop;

    assign eligible = pndng & en_mask;
    assign D_push   = packet;

    rr_priority_picker #(
        .drvrs (drvrs),
        .id_w  (id_w)
    ) u_picker (
        .req       (eligible),
        .last      (last_grant),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    function automatic logic [drvrs-1:0] onehot(input logic [id_w-1:0] id);
        logic [drvrs-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    always_comb begin
        head = '0;
        for (int i = 0; i < drvrs; i++) begin
            if (grant_id == id_w'(i)) head = D_pop[i*pckg_sz +: pckg_sz];
        end
    end

    // Routing is decoded from the FIFO head in POP so push can be registered
    // on the same edge that captures the packet.
    always_comb begin
        route_vec  = '0;
        route_drop = 1'b0;
        dest       = head[pckg_sz-1 -: DEST_W];
        if (dest == broadcast) begin
            route_vec           = '1;
            route_vec[grant_id] = 1'b0;
        end else if (int'(dest) < drvrs) begin
            route_vec[dest[id_w-1:0]] = 1'b1;
        end else begin
            route_drop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pop        <= '0;
            push       <= '0;
            busy       <= 1'b0;
            drop_cnt   <= '0;
            grant_id   <= '0;
            last_grant <= id_w'(drvrs - 1);
            packet     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    push <= '0;
                    if (gnt_valid) begin
                        state    <= POP;
                        grant_id <= gnt_id;
                        pop      <= onehot(gnt_id);
                        busy     <= 1'b1;
                    end
                end
                POP: begin
                    pop        <= '0;
                    packet     <= head;
                    last_grant <= grant_id;
                    push       <= route_vec;
                    if (route_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                    state      <= PUSH;
                end
                PUSH: begin
                    push <= '0;
                    if (gnt_valid) begin
                        state    <= POP;
                        grant_id <= gnt_id;
                        pop      <= onehot(gnt_id);
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    pop   <= '0;
                    push  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
